// File: rtl/tawas_mdu_pkg.sv
// ---------------------------------------------------------------------------
// tawas_mdu_pkg
// Shared definitions for the Tawas multiply/divide scheduler slice:
//   - mdu_op_t    : request opcode encodings (MUL, MULHU, DIVU, REMU)
//   - mdu_state_t : scheduler FSM states (IDLE, LOAD, RUN, DONE)
//   - NUM_SLICES  : number of Tawas slices sharing the engine
//   - ITERS       : engine iterations per operation (one bit per cycle)
//   - rr_pick     : round-robin winner search helper
// Optional feature macro: TAWAS_MDU_DIV_EN (divider datapath present).
// ---------------------------------------------------------------------------
package tawas_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam int NUM_SLICES = 4;
    localparam int ITERS      = 32;

    // Returns {found, index} of the first set bit of elig strictly after
    // last, wrapping modulo 4. The search walks from the furthest candidate
    // back to the nearest so the nearest eligible slot is the final write.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                           input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (elig[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tawas_mdu_core.sv
// ---------------------------------------------------------------------------
// tawas_mdu_core
// Iterative unsigned multiply/divide engine, one result bit per cycle.
//   Multiply : shift-add; acc = {partial, multiplier}, product ends in acc.
//   Divide   : restoring; acc = {remainder, dividend/quotient}.
//   After ITERS steps acc[31:0] holds the low product or the quotient and
//   acc[63:32] holds the high product or the remainder.
// Optional feature macro: TAWAS_MDU_DIV_EN (without it the divide datapath
// is absent and divide loads are ignored).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture operands and clear the iteration counter
//   step        perform one iteration
//   div         operation at load is a divide (DIVU/REMU)
//   op_a, op_b  operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   acc         64-bit accumulator
//   last        current step is the final iteration
// ---------------------------------------------------------------------------
module tawas_mdu_core
    import tawas_mdu_pkg::*;
#(
    parameter int ITER_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] acc,
    output logic        last
);

    logic [31:0]       addend;
    logic [ITER_W-1:0] count;
    logic [63:0]       acc_next;
    logic [32:0]       mul_sum;
`ifdef TAWAS_MDU_DIV_EN
    logic              is_div;
    logic [32:0]       div_shift;
    logic              div_ge;
    logic [31:0]       div_rem;
`endif

    assign last = (count == ITER_W'(ITERS - 1));

    // Next accumulator value for one iteration. Multiply adds the
    // multiplicand into the upper half when the current multiplier bit is
    // set, then shifts the 65-bit result right. Divide shifts the remainder
    // left by one, pulling in the next dividend bit, and subtracts the
    // divisor when it fits; the quotient bit enters at the bottom. A zero
    // divisor always "fits", giving all-ones quotient and remainder = A.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef TAWAS_MDU_DIV_EN
        div_shift = acc[63:31];
        div_ge    = (div_shift >= {1'b0, addend});
        div_rem   = div_ge ? 32'(div_shift - {1'b0, addend}) : div_shift[31:0];
        if (is_div) begin
            acc_next = {div_rem, acc[30:0], div_ge};
        end
`endif
    end

    // Operand capture on load, one iteration per step. The addend register
    // holds whichever operand is repeatedly added or subtracted: the
    // multiplicand for multiply, the divisor for divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            addend <= '0;
            count  <= '0;
`ifdef TAWAS_MDU_DIV_EN
            is_div <= 1'b0;
`endif
        end else if (load) begin
            count <= '0;
`ifdef TAWAS_MDU_DIV_EN
            is_div <= div;
            if (div) begin
                acc    <= {32'd0, op_a};
                addend <= op_b;
            end else begin
                acc    <= {32'd0, op_b};
                addend <= op_a;
            end
`else
            if (!div) begin
                acc    <= {32'd0, op_b};
                addend <= op_a;
            end
`endif
        end else if (step) begin
            acc   <= acc_next;
            count <= count + ITER_W'(1);
        end
    end

endmodule

// File: rtl/tawas_mdu_sched.sv
// ---------------------------------------------------------------------------
// tawas_mdu_sched
// Shares one iterative multiply/divide engine between the four Tawas
// slices. Each slice owns one request slot; slots are granted to the engine
// round-robin and each result is returned in its owner's issue slot.
// Optional feature macro: TAWAS_MDU_DIV_EN. When undefined, DIVU/REMU are
// accepted but complete the cycle after acceptance with result 0 and never
// use the engine.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   slice                 current issue slice (rotates 0..3)
//   req_vld/slice/op/a/b  request strobe, owner, opcode, operands
//   abort_vld/abort_slice discard the request of a slice
//   pend                  per-slice request outstanding
//   busy                  engine FSM not idle
//   req_err               sticky: a request was dropped
//   rtn_vld/slice/data    combinational result return for the current slice
// ---------------------------------------------------------------------------
module tawas_mdu_sched
    import tawas_mdu_pkg::*;
#(
    parameter int         ITER_W  = 6,
    parameter logic [1:0] RR_INIT = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  slice,
    input  logic        req_vld,
    input  logic [1:0]  req_slice,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        abort_vld,
    input  logic [1:0]  abort_slice,
    output logic [3:0]  pend,
    output logic        busy,
    output logic        req_err,
    output logic        rtn_vld,
    output logic [1:0]  rtn_slice,
    output logic [31:0] rtn_data
);

    mdu_state_t  state;
    logic [1:0]  cur;
    logic [1:0]  last_grant;
    logic [1:0]  slot_op [NUM_SLICES];
    logic [31:0] slot_a  [NUM_SLICES];
    logic [31:0] slot_b  [NUM_SLICES];
    logic [31:0] res     [NUM_SLICES];
    logic [3:0]  done;

    logic [3:0]  abort_hit;
    logic [3:0]  elig;
    logic [2:0]  pick;
    logic        rtn_hit;
    logic        accept;
    logic [31:0] result_word;
    logic [63:0] acc;
    logic        core_last;

    tawas_mdu_core #(
        .ITER_W (ITER_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ST_LOAD),
        .step  (state == ST_RUN),
        .div   (slot_op[cur][1]),
        .op_a  (slot_a[cur]),
        .op_b  (slot_b[cur]),
        .acc   (acc),
        .last  (core_last)
    );

    assign busy = (state != ST_IDLE);

    // Per-cycle decisions. An abort for a slice suppresses that slice's
    // return and any request for it in the same cycle. A request for a
    // pending slice is only accepted when that slice is returning on this
    // very edge, which frees the slot. Slots already finished or being
    // aborted never compete for the engine.
    always_comb begin
        abort_hit = '0;
        if (abort_vld) begin
            abort_hit[abort_slice] = 1'b1;
        end
        rtn_hit = done[slice] && !abort_hit[slice];
        accept  = req_vld && !abort_hit[req_slice] &&
                  (!pend[req_slice] || (rtn_hit && (slice == req_slice)));
        for (int i = 0; i < NUM_SLICES; i++) begin
`ifdef TAWAS_MDU_DIV_EN
            elig[i] = pend[i] && !done[i] && !abort_hit[i];
`else
            elig[i] = pend[i] && !done[i] && !abort_hit[i] && !slot_op[i][1];
`endif
        end
        pick        = rr_pick(elig, last_grant);
        result_word = slot_op[cur][0] ? acc[63:32] : acc[31:0];
    end

    // The return is presented in the owner's own issue slot, next to the
    // arithmetic unit's writeback, so the data and slice are zeroed when no
    // result is being returned.
    assign rtn_vld   = rtn_hit;
    assign rtn_slice = rtn_hit ? slice : 2'd0;
    assign rtn_data  = rtn_hit ? res[slice] : 32'd0;

    // Engine FSM. IDLE grants the nearest eligible slot after the previous
    // winner; LOAD primes the engine; RUN iterates until the last step;
    // DONE hands the result to the slot. Aborting the running slot drops
    // straight back to IDLE so the next arbitration happens immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur        <= 2'd0;
            last_grant <= RR_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick[2]) begin
                        cur        <= pick[1:0];
                        last_grant <= pick[1:0];
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_RUN;
                ST_RUN: begin
                    if (core_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if ((state != ST_IDLE) && abort_hit[cur]) begin
                state <= ST_IDLE;
            end
        end
    end

    // Slot bookkeeping. Later assignments take priority: completion, then
    // return (frees the slot), then a new request (may reuse the slot on
    // the same edge), then abort, which beats everything for its slice.
    // req_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            done    <= '0;
            req_err <= 1'b0;
            for (int i = 0; i < NUM_SLICES; i++) begin
                slot_op[i] <= 2'd0;
                slot_a[i]  <= 32'd0;
                slot_b[i]  <= 32'd0;
                res[i]     <= 32'd0;
            end
        end else begin
            if (req_vld && !accept) begin
                req_err <= 1'b1;
            end
            for (int i = 0; i < NUM_SLICES; i++) begin
                if ((state == ST_DONE) && (cur == 2'(i)) && !abort_hit[i]) begin
                    res[i]  <= result_word;
                    done[i] <= 1'b1;
                end
`ifndef TAWAS_MDU_DIV_EN
                if (pend[i] && !done[i] && slot_op[i][1]) begin
                    res[i]  <= 32'd0;
                    done[i] <= 1'b1;
                end
`endif
                if (rtn_hit && (slice == 2'(i))) begin
                    pend[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
                if (accept && (req_slice == 2'(i))) begin
                    pend[i]    <= 1'b1;
                    slot_op[i] <= req_op;
                    slot_a[i]  <= req_a;
                    slot_b[i]  <= req_b;
                end
                if (abort_hit[i]) begin
                    pend[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tawas_mdu_sched.sv
// ---------------------------------------------------------------------------
// tb_tawas_mdu_sched
// Directed bench for tawas_mdu_sched: multiply/divide results, return slot
// and latency, round-robin order, duplicate-request drop, abort and
// mid-operation reset. Expected values are hand-computed constants.
// Honours TAWAS_MDU_DIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_tawas_mdu_sched;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;
`ifdef TAWAS_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  slice;
    logic        req_vld;
    logic [1:0]  req_slice;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        abort_vld;
    logic [1:0]  abort_slice;
    logic [3:0]  pend;
    logic        busy;
    logic        req_err;
    logic        rtn_vld;
    logic [1:0]  rtn_slice;
    logic [31:0] rtn_data;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    tawas_mdu_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slice       (slice),
        .req_vld     (req_vld),
        .req_slice   (req_slice),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .abort_vld   (abort_vld),
        .abort_slice (abort_slice),
        .pend        (pend),
        .busy        (busy),
        .req_err     (req_err),
        .rtn_vld     (rtn_vld),
        .rtn_slice   (rtn_slice),
        .rtn_data    (rtn_data)
    );

    // 10 ns clock and an edge counter; cyc equals the number of rising
    // edges seen so far, which is how request and return times are compared.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue slice rotates 0,1,2,3 every cycle, changed just after the edge.
    initial begin
        slice = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            slice = slice + 2'd1;
        end
    end

    // Safety net so the run always ends even if the design stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one request for one edge; n is the edge count of the capture.
    task automatic applyStimulus(input logic [1:0] s, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output int n);
        req_vld   = 1'b1;
        req_slice = s;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        n = cyc;
    endtask

    task automatic waitCycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the next returned result, sampled mid-cycle.
    task automatic waitAny(output logic [1:0] s, output logic [31:0] d,
                           output int at, output bit ok);
        int i;
        ok = 1'b0;
        s  = 2'd0;
        d  = 32'd0;
        at = 0;
        i  = 0;
        while (!ok && i < 200) begin
            @(negedge clk);
            if (rtn_vld) begin
                ok = 1'b1;
                s  = rtn_slice;
                d  = rtn_data;
                at = cyc;
            end
            i++;
        end
        @(posedge clk);
        #1;
    endtask

    // Counts returns over k cycles; used where nothing must come back.
    task automatic waitQuiet(input int k, output int seen);
        seen = 0;
        repeat (k) begin
            @(negedge clk);
            if (rtn_vld) seen++;
        end
        @(posedge clk);
        #1;
    endtask

    // One request on an idle scheduler, checked for data, owner and the
    // exact return slot: the first cycle >= n+lat whose slice is the owner.
    task automatic runOne(input logic [1:0] s, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
        int n, at, lat;
        logic [1:0] rs;
        logic [31:0] rd;
        bit ok;
        lat = (DIV_EN || !op[1]) ? 35 : 1;
        applyStimulus(s, op, a, b, n);
        checkOutput({tag, "_pend_set"}, pend[s], 1);
        waitAny(rs, rd, at, ok);
        checkOutput({tag, "_returned"}, ok, 1);
        checkOutput({tag, "_slice"}, rs, s);
        checkOutput({tag, "_data"}, rd, expv);
        checkOutput({tag, "_latency"}, (at >= n + lat) && (at <= n + lat + 3), 1);
        checkOutput({tag, "_pend_clr"}, pend, 0);
    endtask

    initial begin
        int n, at, prev_at, seen;
        logic [1:0] rs;
        logic [31:0] rd;
        bit ok;
        logic [1:0]  rr_slice [4];
        logic [31:0] rr_data  [4];

        rst_n = 1'b0; req_vld = 1'b0; req_slice = 2'd0; req_op = 2'd0;
        req_a = 32'd0; req_b = 32'd0; abort_vld = 1'b0; abort_slice = 2'd0;
        waitCycles(3);
        checkOutput("rst_pend", pend, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_err", req_err, 0);
        checkOutput("rst_rtn_vld", rtn_vld, 0);
        checkOutput("rst_rtn_data", rtn_data, 0);
        checkOutput("rst_rtn_slice", rtn_slice, 0);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] basic multiply and divide results");
        runOne(2'd1, OP_MUL, 32'd7, 32'd6, 32'd42, "mul_7x6");
        runOne(2'd2, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        runOne(2'd2, OP_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, "divu_100_7");
        runOne(2'd2, OP_REMU, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, "remu_100_7");
        runOne(2'd0, OP_DIVU, 32'd5, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, "divu_by0");
        runOne(2'd3, OP_REMU, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, "remu_by0");

        $display("[TB] round-robin after a grant to slice 2");
        rr_slice[0] = 2'd2; rr_data[0] = 32'd15;
        rr_slice[1] = 2'd3; rr_data[1] = 32'd1;
        rr_slice[2] = 2'd0; rr_data[2] = 32'd1000000;
        rr_slice[3] = 2'd1; rr_data[3] = 32'hFFFFFFFE;
        applyStimulus(2'd2, OP_MUL, 32'd3, 32'd5, n);
        applyStimulus(2'd3, OP_MULHU, 32'h00010000, 32'h00010000, at);
        applyStimulus(2'd0, OP_MUL, 32'd1000, 32'd1000, at);
        applyStimulus(2'd1, OP_MUL, 32'hFFFFFFFF, 32'd2, at);
        checkOutput("rr_pend_all", pend, 4'b1111);
        checkOutput("rr_busy", busy, 1);
        prev_at = 0;
        for (int k = 0; k < 4; k++) begin
            waitAny(rs, rd, at, ok);
            checkOutput($sformatf("rr%0d_returned", k), ok, 1);
            checkOutput($sformatf("rr%0d_slice", k), rs, rr_slice[k]);
            checkOutput($sformatf("rr%0d_data", k), rd, rr_data[k]);
            if (k == 0) begin
                checkOutput("rr0_latency", (at >= n + 35) && (at <= n + 38), 1);
            end else begin
                checkOutput($sformatf("rr%0d_spacing", k),
                            (at - prev_at >= 32) && (at - prev_at <= 38), 1);
            end
            prev_at = at;
        end
        checkOutput("rr_pend_clr", pend, 0);

        $display("[TB] duplicate request while pending");
        applyStimulus(2'd0, OP_MUL, 32'd9, 32'd9, n);
        checkOutput("dup_err_before", req_err, 0);
        applyStimulus(2'd0, OP_MUL, 32'd2, 32'd2, at);
        checkOutput("dup_err", req_err, 1);
        checkOutput("dup_pend", pend, 4'b0001);
        waitAny(rs, rd, at, ok);
        checkOutput("dup_returned", ok, 1);
        checkOutput("dup_slice", rs, 2'd0);
        checkOutput("dup_data", rd, 32'd81);
        waitQuiet(40, seen);
        checkOutput("dup_no_second", seen, 0);
        checkOutput("dup_err_sticky", req_err, 1);

        $display("[TB] abort of the running slice");
        applyStimulus(2'd2, OP_MUL, 32'd13, 32'd3, n);
        applyStimulus(2'd3, OP_MUL, 32'd11, 32'd11, at);
        waitCycles(11);
        checkOutput("abort_busy_run", busy, 1);
        abort_vld   = 1'b1;
        abort_slice = 2'd2;
        waitCycles(1);
        abort_vld = 1'b0;
        checkOutput("abort_busy_idle", busy, 0);
        checkOutput("abort_pend", pend, 4'b1000);
        waitCycles(1);
        checkOutput("abort_regrant", busy, 1);
        waitAny(rs, rd, at, ok);
        checkOutput("abort_returned", ok, 1);
        checkOutput("abort_next_slice", rs, 2'd3);
        checkOutput("abort_next_data", rd, 32'd121);
        waitQuiet(40, seen);
        checkOutput("abort_no_ret", seen, 0);

        $display("[TB] reset during RUN");
        applyStimulus(2'd1, OP_MUL, 32'd5, 32'd5, n);
        waitCycles(15);
        checkOutput("mrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("mrst_pend", pend, 0);
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_req_err", req_err, 0);
        checkOutput("mrst_rtn_vld", rtn_vld, 0);
        checkOutput("mrst_rtn_data", rtn_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitQuiet(45, seen);
        checkOutput("mrst_lost", seen, 0);
        runOne(2'd0, OP_MUL, 32'd3, 32'd4, 32'd12, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
